// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: turns decoded fields into 32-bit machine words and
// streams them into the IMEM write port at auto-incrementing word addresses.
module legv8_instr_encoder #(
    parameter int ADDR_W = 64
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [25:0]       imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [15:0]       word_count,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              clr_err
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_LDUR = 4'd4,
        OP_STUR = 4'd5,
        OP_CBZ  = 4'd6,
        OP_CBNZ = 4'd7,
        OP_B    = 4'd8,
        OP_BL   = 4'd9,
        OP_LSL  = 4'd10,
        OP_LSR  = 4'd11
    } op_e;

    localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
    localparam logic [1:0] ERR_IMM_RANGE  = 2'd2;
    localparam logic [1:0] ERR_SHAMT      = 2'd3;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [15:0]       word_count_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [31:0]       enc_data;
    logic              chk_err;
    logic [1:0]        chk_code;
    logic              d_ok;
    logic              cb_ok;
    logic              sh_ok;
    logic              accept;
    logic              handshake;
    logic [ADDR_W-1:0] base_aligned;

    assign d_ok  = (imm == {{17{imm[8]}}, imm[8:0]});
    assign cb_ok = (imm == {{7{imm[18]}}, imm[18:0]});
    assign sh_ok = (imm[25:6] == 20'd0);

    // The encoded word and its legality are computed for every request; the
    // register stage decides whether it is written or only flagged.
    always_comb begin
        enc_data = 32'd0;
        chk_err  = 1'b0;
        chk_code = 2'd0;
        case (op_sel)
            OP_ADD:  enc_data = {11'b10001011000, rm, 6'd0, rn, rd};
            OP_SUB:  enc_data = {11'b11001011000, rm, 6'd0, rn, rd};
            OP_AND:  enc_data = {11'b10001010000, rm, 6'd0, rn, rd};
            OP_ORR:  enc_data = {11'b10101010000, rm, 6'd0, rn, rd};
            OP_LDUR: begin
                enc_data = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
                if (!d_ok) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_IMM_RANGE;
                end
            end
            OP_STUR: begin
                enc_data = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
                if (!d_ok) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_IMM_RANGE;
                end
            end
            OP_CBZ: begin
                enc_data = {8'b10110100, imm[18:0], rd};
                if (!cb_ok) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_IMM_RANGE;
                end
            end
            OP_CBNZ: begin
                enc_data = {8'b10110101, imm[18:0], rd};
                if (!cb_ok) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_IMM_RANGE;
                end
            end
            OP_B:    enc_data = {6'b000101, imm};
            OP_BL:   enc_data = {6'b100101, imm};
            OP_LSL: begin
                enc_data = {11'b11010011011, 5'd0, imm[5:0], rn, rd};
                if (!sh_ok) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_SHAMT;
                end
            end
            OP_LSR: begin
                enc_data = {11'b11010011010, 5'd0, imm[5:0], rn, rd};
                if (!sh_ok) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_SHAMT;
                end
            end
            default: begin
                chk_err  = 1'b1;
                chk_code = ERR_ILLEGAL_OP;
            end
        endcase
    end

    assign in_ready     = Reset_L && (!wr_en_q || wr_ready);
    assign accept       = in_valid && in_ready;
    assign handshake    = wr_en_q && wr_ready;
    assign base_aligned = base_addr & ~ADDR_W'(3);

    // base_load beats the handshake increment; a pending word keeps its data
    // and simply lands at the newly loaded address.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
            word_count_q <= 16'd0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            if (accept && !chk_err) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= enc_data;
            end else if (handshake) begin
                wr_en_q <= 1'b0;
            end

            if (base_load) begin
                wr_addr_q <= base_aligned;
            end else if (handshake) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(4);
            end

            if (handshake) begin
                word_count_q <= word_count_q + 16'd1;
            end

            // An error on the same edge as clr_err wins and records a fresh cause.
            if (accept && chk_err) begin
                err_q <= 1'b1;
                if (!err_q || clr_err) begin
                    err_code_q <= chk_code;
                end
            end else if (clr_err) begin
                err_q      <= 1'b0;
                err_code_q <= 2'd0;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder: vector table plus scoreboard of
// expected IMEM writes, with hand sequences for stalls, errors, base loads and reset.
module tb_legv8_instr_encoder;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wrExp_t;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        inValid;
    logic        inReady;
    logic [3:0]  opSel;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic        baseLoad;
    logic [63:0] baseAddr;
    logic        wrEn;
    logic        wrReady;
    logic [63:0] wrAddr;
    logic [31:0] wrData;
    logic [15:0] wordCount;
    logic        err;
    logic [1:0]  errCode;
    logic        clrErr;

    logic        s8InValid;
    logic        s8InReady;
    logic [3:0]  s8OpSel;
    logic [25:0] s8Imm;
    logic        s8BaseLoad;
    logic [7:0]  s8BaseAddr;
    logic        s8WrEn;
    logic        s8WrReady;
    logic [7:0]  s8WrAddr;
    logic [31:0] s8WrData;
    logic [15:0] s8WordCount;
    logic        s8Err;
    logic [1:0]  s8ErrCode;

    int          total = 0;
    int          bad = 0;
    logic [63:0] expAddr;
    int          expCount;
    wrExp_t      expQ[$];
    wrExp_t      monExp;
    vec_t        vecs[11];

    legv8_instr_encoder #(.ADDR_W(64)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .in_valid(inValid), .in_ready(inReady),
        .op_sel(opSel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .base_load(baseLoad), .base_addr(baseAddr), .wr_en(wrEn), .wr_ready(wrReady),
        .wr_addr(wrAddr), .wr_data(wrData), .word_count(wordCount),
        .err(err), .err_code(errCode), .clr_err(clrErr)
    );

    legv8_instr_encoder #(.ADDR_W(8)) dut8 (
        .CLK(CLK), .Reset_L(Reset_L), .in_valid(s8InValid), .in_ready(s8InReady),
        .op_sel(s8OpSel), .rd(rd), .rn(rn), .rm(rm), .imm(s8Imm),
        .base_load(s8BaseLoad), .base_addr(s8BaseAddr), .wr_en(s8WrEn), .wr_ready(s8WrReady),
        .wr_addr(s8WrAddr), .wr_data(s8WrData), .word_count(s8WordCount),
        .err(s8Err), .err_code(s8ErrCode), .clr_err(clrErr)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Drives one request and holds it until accepted; legal words go into the scoreboard.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] d, input logic [4:0] n,
                                 input logic [4:0] m, input logic [25:0] im,
                                 input logic push, input logic [31:0] expData);
        logic accepted;
        opSel   = op;
        rd      = d;
        rn      = n;
        rm      = m;
        imm     = im;
        inValid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 40 && !accepted; c++) begin
            @(negedge CLK);
            accepted = inReady;
            @(posedge CLK);
            #1;
        end
        inValid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: op=%0d never accepted, required acceptance", op);
        end else if (push) begin
            expQ.push_back('{expAddr, expData});
            expAddr  += 64'd4;
            expCount += 1;
        end
    endtask

    task automatic drain();
        logic done;
        wrReady = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            done = (expQ.size() == 0) && !wrEn;
        end
        @(posedge CLK);
        #1;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d writes outstanding, required 0", expQ.size());
        end
    endtask

    // Scoreboard consumer: every completed IMEM write must match the oldest expectation.
    always @(negedge CLK) begin
        if (wrEn && wrReady) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required no write", wrAddr, wrData);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wr_addr", wrAddr, monExp.addr);
                checkOutput("wr_data", {32'd0, wrData}, {32'd0, monExp.data});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'd4,  5'd5,  5'd2,  5'd0,  26'd8,        32'hF8408045};
        vecs[1]  = '{4'd6,  5'd1,  5'd0,  5'd0,  26'h3FFFFFE,  32'hB4FFFFC1};
        vecs[2]  = '{4'd8,  5'd0,  5'd0,  5'd0,  26'd3,        32'h14000003};
        vecs[3]  = '{4'd10, 5'd4,  5'd1,  5'd0,  26'd3,        32'hD3600C24};
        vecs[4]  = '{4'd1,  5'd0,  5'd31, 5'd31, 26'd0,        32'hCB1F03E0};
        vecs[5]  = '{4'd2,  5'd7,  5'd8,  5'd9,  26'd0,        32'h8A090107};
        vecs[6]  = '{4'd5,  5'd6,  5'd3,  5'd0,  26'h3FFFF00,  32'hF8100066};
        vecs[7]  = '{4'd7,  5'd2,  5'd0,  5'd0,  26'h003FFFF,  32'hB57FFFE2};
        vecs[8]  = '{4'd9,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF,  32'h97FFFFFF};
        vecs[9]  = '{4'd11, 5'd9,  5'd10, 5'd0,  26'd63,       32'hD340FD49};
        vecs[10] = '{4'd4,  5'd0,  5'd0,  5'd0,  26'd255,      32'hF84FF000};

        Reset_L = 1'b0;
        inValid = 1'b0; opSel = 4'd0; rd = 5'd0; rn = 5'd0; rm = 5'd0; imm = 26'd0;
        baseLoad = 1'b0; baseAddr = 64'd0; wrReady = 1'b1; clrErr = 1'b0;
        s8InValid = 1'b0; s8OpSel = 4'd0; s8Imm = 26'd0; s8BaseLoad = 1'b0;
        s8BaseAddr = 8'd0; s8WrReady = 1'b1;
        expAddr = 64'd0;
        expCount = 0;

        #12;
        checkOutput("reset_wr_en", {63'd0, wrEn}, 64'd0);
        checkOutput("reset_wr_addr", wrAddr, 64'd0);
        checkOutput("reset_wr_data", {32'd0, wrData}, 64'd0);
        checkOutput("reset_word_count", {48'd0, wordCount}, 64'd0);
        checkOutput("reset_err", {63'd0, err}, 64'd0);
        checkOutput("reset_err_code", {62'd0, errCode}, 64'd0);
        @(posedge CLK);
        #1;
        Reset_L = 1'b1;
        #1;
        checkOutput("idle_in_ready", {63'd0, inReady}, 64'd1);
        checkOutput("s8_idle_in_ready", {63'd0, s8InReady}, 64'd1);

        applyStimulus(4'd0, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1, 32'h8B020023);
        drain();
        checkOutput("word_count_after_add", {48'd0, wordCount}, 64'd1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, 1'b1, vecs[i].data);
        end
        drain();
        checkOutput("word_count_after_table", {48'd0, wordCount}, 64'(expCount));

        // Stall: first word parked, second request waiting behind it.
        wrReady = 1'b0;
        applyStimulus(4'd3, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'hAA030041);
        fork
            applyStimulus(4'd1, 5'd0, 5'd31, 5'd31, 26'd0, 1'b1, 32'hCB1F03E0);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    checkOutput("stall_in_ready", {63'd0, inReady}, 64'd0);
                    checkOutput("stall_wr_en", {63'd0, wrEn}, 64'd1);
                    checkOutput("stall_wr_data", {32'd0, wrData}, 64'h00000000AA030041);
                end
                @(posedge CLK);
                #1;
                wrReady = 1'b1;
            end
        join
        drain();

        applyStimulus(4'd4, 5'd1, 5'd1, 5'd0, 26'd256, 1'b0, 32'd0);
        @(negedge CLK);
        checkOutput("ldur_range_err", {63'd0, err}, 64'd1);
        checkOutput("ldur_range_code", {62'd0, errCode}, 64'd2);
        checkOutput("ldur_range_no_write", {63'd0, wrEn}, 64'd0);
        @(posedge CLK); #1;
        applyStimulus(4'd13, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);
        checkOutput("sticky_code", {62'd0, errCode}, 64'd2);
        clrErr = 1'b1;
        @(posedge CLK); #1;
        clrErr = 1'b0;
        checkOutput("clr_err", {63'd0, err}, 64'd0);
        checkOutput("clr_err_code", {62'd0, errCode}, 64'd0);
        applyStimulus(4'd13, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);
        checkOutput("illegal_op_code", {62'd0, errCode}, 64'd1);
        clrErr = 1'b1;
        @(posedge CLK); #1;
        clrErr = 1'b0;
        applyStimulus(4'd10, 5'd1, 5'd1, 5'd0, 26'd64, 1'b0, 32'd0);
        checkOutput("shamt_code", {62'd0, errCode}, 64'd3);
        clrErr = 1'b1;
        applyStimulus(4'd14, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);
        clrErr = 1'b0;
        checkOutput("err_beats_clr", {63'd0, err}, 64'd1);
        checkOutput("err_word_count_held", {48'd0, wordCount}, 64'(expCount));
        checkOutput("err_wr_addr_held", wrAddr, expAddr);
        clrErr = 1'b1;
        @(posedge CLK); #1;
        clrErr = 1'b0;

        // Base load racing a handshake: the finishing write keeps the old address.
        baseLoad = 1'b1;
        baseAddr = 64'h20;
        @(posedge CLK); #1;
        baseLoad = 1'b0;
        expAddr = 64'h20;
        checkOutput("base_load_addr", wrAddr, 64'h20);
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 26'd5, 1'b1, 32'h14000005);
        baseLoad = 1'b1;
        baseAddr = 64'h103;
        @(posedge CLK); #1;
        baseLoad = 1'b0;
        expAddr = 64'h100;
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 26'd6, 1'b1, 32'h14000006);
        drain();

        wrReady = 1'b0;
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 26'd7, 1'b0, 32'd0);
        baseLoad = 1'b1;
        baseAddr = 64'h200;
        @(posedge CLK); #1;
        baseLoad = 1'b0;
        expQ.push_back('{64'h200, 32'h14000007});
        expAddr = 64'h204;
        expCount += 1;
        drain();
        checkOutput("pending_after_base_addr", wrAddr, 64'h204);
        checkOutput("word_count_after_base", {48'd0, wordCount}, 64'(expCount));

        // Narrow address wraps past the top of the 8-bit space.
        s8BaseLoad = 1'b1;
        s8BaseAddr = 8'hFE;
        @(posedge CLK); #1;
        s8BaseLoad = 1'b0;
        checkOutput("s8_base_aligned", {56'd0, s8WrAddr}, 64'hFC);
        s8OpSel = 4'd8;
        s8Imm = 26'd1;
        s8InValid = 1'b1;
        @(posedge CLK); #1;
        s8Imm = 26'd2;
        @(negedge CLK);
        checkOutput("s8_first_en", {63'd0, s8WrEn}, 64'd1);
        checkOutput("s8_first_addr", {56'd0, s8WrAddr}, 64'hFC);
        checkOutput("s8_first_data", {32'd0, s8WrData}, 64'h14000001);
        @(posedge CLK); #1;
        s8InValid = 1'b0;
        @(negedge CLK);
        checkOutput("s8_wrap_addr", {56'd0, s8WrAddr}, 64'h00);
        checkOutput("s8_second_data", {32'd0, s8WrData}, 64'h14000002);
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("s8_idle_en", {63'd0, s8WrEn}, 64'd0);
        checkOutput("s8_word_count", {48'd0, s8WordCount}, 64'd2);
        checkOutput("s8_no_err", {61'd0, s8Err, s8ErrCode}, 64'd0);
        @(posedge CLK); #1;

        // Reset during a stall clears state immediately and drops the parked word.
        wrReady = 1'b0;
        applyStimulus(4'd4, 5'd0, 5'd0, 5'd0, 26'd300, 1'b0, 32'd0);
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 26'd9, 1'b0, 32'd0);
        checkOutput("pre_reset_wr_en", {63'd0, wrEn}, 64'd1);
        checkOutput("pre_reset_err", {63'd0, err}, 64'd1);
        #1;
        Reset_L = 1'b0;
        #1;
        checkOutput("async_reset_wr_en", {63'd0, wrEn}, 64'd0);
        checkOutput("async_reset_wr_addr", wrAddr, 64'd0);
        checkOutput("async_reset_word_count", {48'd0, wordCount}, 64'd0);
        checkOutput("async_reset_err", {63'd0, err}, 64'd0);
        #3;
        Reset_L = 1'b1;
        wrReady = 1'b1;
        expAddr = 64'd0;
        expCount = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput("post_reset_no_write", {63'd0, wrEn}, 64'd0);
        end
        checkOutput("post_reset_word_count", {48'd0, wordCount}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
